ball_bounce_control: RTL

- Upstream stage of the ball movers: replaces the switch-driven direction source and supplies horizontal/vertical direction bits plus a run enable.
- Snoops the pixel stream (ball video, paddle video, blanking) during each active frame and records edge contacts and paddle hits.
- Applies the resulting bounce decisions once per frame, at the start of vertical blanking.
- Runs the serve/play/miss game flow and keeps hit and miss counters.

---
 rtl/ball_bounce_control.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/ball_bounce_control.sv
`default_nettype none
// ============================================================================
// ball_bounce_control
// Snoops the pixel stream for wall/paddle contacts, applies bounces once per
// frame and runs the serve/play/miss flow. Revision: 1.0
// ============================================================================
module ball_bounce_control #(
    parameter int p_H_ACTIVE    = 640,
    parameter int p_V_ACTIVE    = 480,
    parameter int p_HOLD_FRAMES = 60
) (
    input  logic       i_Clk,
    input  logic       i_Rst_L,
    input  logic       i_HBlank,
    input  logic       i_VBlank,
    input  logic       i_Ball_Video,
    input  logic       i_Paddle_Video,
    input  logic       i_Serve,
    output logic       o_HDir,
    output logic       o_VDir,
    output logic       o_Run,
    output logic       o_Miss,
    output logic [7:0] o_Hits,
    output logic [3:0] o_Misses
);

    localparam int XW = (p_H_ACTIVE > 1) ? $clog2(p_H_ACTIVE) : 1;
    localparam int YW = (p_V_ACTIVE > 1) ? $clog2(p_V_ACTIVE) : 1;
    localparam int HW = $clog2(p_HOLD_FRAMES + 1);
    localparam logic [XW-1:0] c_X_MAX    = XW'(p_H_ACTIVE - 1);
    localparam logic [YW-1:0] c_Y_MAX    = YW'(p_V_ACTIVE - 1);
    localparam logic [HW-1:0] c_HOLD_MAX = HW'(p_HOLD_FRAMES - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_PLAY = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [XW-1:0]   x_q, x_d;
    logic [YW-1:0]   y_q, y_d;
    logic            hblank_q, vblank_q, ev_q, ev_d;
    logic            left_q, right_q, top_q, bottom_q, hit_q;
    logic            left_d, right_d, top_d, bottom_d, hit_d;
    logic            sync1_q, sync2_q, sync3_q;
    logic            hdir_q, hdir_d, vdir_q, vdir_d, miss_q, miss_d;
    logic [7:0]      hits_q, hits_d;
    logic [3:0]      misses_q, misses_d;
    logic [HW-1:0]   hold_q, hold_d;

    logic w_active, w_vfall, w_ball, w_serve_rise;

    assign w_active     = ~i_HBlank & ~i_VBlank;
    assign w_vfall      = vblank_q & ~i_VBlank;
    assign w_ball       = w_active & i_Ball_Video;
    assign w_serve_rise = sync2_q & ~sync3_q;

    // Pixel position tracking and sticky per-frame contact flags
    always_comb begin
        x_d = x_q;
        y_d = y_q;
        if (i_HBlank) begin
            x_d = '0;
        end else if (!i_VBlank && x_q != c_X_MAX) begin
            x_d = x_q + XW'(1);
        end
        if (i_VBlank) begin
            y_d = '0;
        end else if (i_HBlank && !hblank_q && y_q != c_Y_MAX) begin
            y_d = y_q + YW'(1);
        end
        // A frame's first pixel may coincide with the clear, so clear then set
        left_d   = (w_vfall ? 1'b0 : left_q)   | (w_ball && x_q == '0);
        right_d  = (w_vfall ? 1'b0 : right_q)  | (w_ball && x_q == c_X_MAX);
        top_d    = (w_vfall ? 1'b0 : top_q)    | (w_ball && y_q == '0);
        bottom_d = (w_vfall ? 1'b0 : bottom_q) | (w_ball && y_q == c_Y_MAX);
        hit_d    = (w_vfall ? 1'b0 : hit_q)    | (w_ball && i_Paddle_Video);
        ev_d     = i_VBlank & ~vblank_q;
    end

    always_comb begin
        state_d  = state_q;
        hdir_d   = hdir_q;
        vdir_d   = vdir_q;
        miss_d   = 1'b0;
        hits_d   = hits_q;
        misses_d = misses_q;
        hold_d   = hold_q;
        case (state_q)
            S_IDLE: begin
                if (w_serve_rise) begin
                    hdir_d  = 1'b1;
                    state_d = S_PLAY;
                end
            end
            S_PLAY: begin
                if (ev_q) begin
                    if (hit_q && !hdir_q) begin
                        hdir_d = 1'b1;
                        if (hits_q != 8'hFF) hits_d = hits_q + 8'd1;
                    end else if (left_q && !hdir_q) begin
                        miss_d   = 1'b1;
                        misses_d = misses_q + 4'd1;
                        hold_d   = '0;
                        state_d  = S_HOLD;
                    end
                    if (right_q && hdir_q) hdir_d = 1'b0;
                    if (top_q && !bottom_q && !vdir_q) vdir_d = 1'b1;
                    if (bottom_q && !top_q && vdir_q)  vdir_d = 1'b0;
                end
            end
            S_HOLD: begin
                if (ev_q) begin
                    if (hold_q == c_HOLD_MAX) begin
                        hold_d  = '0;
                        state_d = S_IDLE;
                    end else begin
                        hold_d = hold_q + HW'(1);
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            state_q  <= S_IDLE;
            x_q      <= '0;
            y_q      <= '0;
            hblank_q <= 1'b0;
            vblank_q <= 1'b0;
            ev_q     <= 1'b0;
            left_q   <= 1'b0;
            right_q  <= 1'b0;
            top_q    <= 1'b0;
            bottom_q <= 1'b0;
            hit_q    <= 1'b0;
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            sync3_q  <= 1'b0;
            hdir_q   <= 1'b1;
            vdir_q   <= 1'b1;
            miss_q   <= 1'b0;
            hits_q   <= '0;
            misses_q <= '0;
            hold_q   <= '0;
        end else begin
            state_q  <= state_d;
            x_q      <= x_d;
            y_q      <= y_d;
            hblank_q <= i_HBlank;
            vblank_q <= i_VBlank;
            ev_q     <= ev_d;
            left_q   <= left_d;
            right_q  <= right_d;
            top_q    <= top_d;
            bottom_q <= bottom_d;
            hit_q    <= hit_d;
            sync1_q  <= i_Serve;
            sync2_q  <= sync1_q;
            sync3_q  <= sync2_q;
            hdir_q   <= hdir_d;
            vdir_q   <= vdir_d;
            miss_q   <= miss_d;
            hits_q   <= hits_d;
            misses_q <= misses_d;
            hold_q   <= hold_d;
        end
    end

    assign o_HDir   = hdir_q;
    assign o_VDir   = vdir_q;
    assign o_Run    = (state_q == S_PLAY);
    assign o_Miss   = miss_q;
    assign o_Hits   = hits_q;
    assign o_Misses = misses_q;

endmodule
`default_nettype wire
